clk_seq_ctrl: RTL and testbench
===============================

# clk_seq_ctrl

Sequences the clocking resource and the sample-rate strobe for the capture datapath. The block waits for the PLL lock indication, holds for a programmable stable interval, and only then releases the datapath reset. In run mode it emits a one-cycle `sample_en` every N cycles, where N is a divide ratio changed through a req/ack handshake and applied only on a sample-period boundary. It sits between the clock-generation wrapper and the ADC capture/trigger logic, clocked by the fast sample clock.

## Interface
- `DIV_W`, 16, width of the divide ratio and divide counter.
- `LOCK_HOLD`, 1024, consecutive cycles of synchronized lock required before `dp_rst_n` is released (≥1).
- `DEF_DIV`, 4, divide ratio loaded at reset (≥1).

- `sys_clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  PLL lock indication, asynchronous to `sys_clk`.
- `div_req`  in  1  divide-change request; held high by the requester until `div_ack`.
- `div_val`  in  DIV_W  requested divide ratio; 0 is treated as 1.
- `div_ack`  out  1  one-cycle pulse when the requested ratio becomes active.
- `dp_rst_n`  out  1  datapath reset, active-low, registered.
- `sample_en`  out  1  one-cycle sample strobe, registered.
- `state`  out  2  status: 0 = WAIT_LOCK, 1 = HOLD, 2 = RUN.

## Operation
- **Reset values:** `state` = WAIT_LOCK, `dp_rst_n` = 0, `sample_en` = 0, `div_ack` = 0, active ratio = DEF_DIV, pending = 0, counters = 0, sync flops = 0.
- **Lock synchronization:** `pll_locked` passes through a 2-flop synchronizer. `lock_s` is the second flop.
- **WAIT_LOCK:**
  - `dp_rst_n` = 0 and `sample_en` = 0.
  - If `lock_s` = 1, go to HOLD with hold counter = 0.
- **HOLD:**
  - The hold counter increments each cycle.
  - If `lock_s` = 0, go to WAIT_LOCK.
  - Else, if hold counter = LOCK_HOLD−1, go to RUN. `dp_rst_n` goes to 1 on that same edge and the divide counter is cleared.
- **RUN:**
  - The divide counter increments each cycle.
  - When counter = active−1: the counter wraps to 0 and `sample_en` is registered to 1 for one cycle.
  - With active = 1, `sample_en` stays high continuously.
- **Lock loss:** if `lock_s` = 0 in HOLD or RUN, go to WAIT_LOCK on that edge. `dp_rst_n` = 0 and `sample_en` = 0 on the same edge. The active ratio is retained.
- **Divide change:**
  - When `div_req` = 1 and pending = 0, latch max(`div_val`, 1) into the pending register and set pending.
  - While pending = 1, `div_req` is ignored.
  - In RUN, the pending ratio is applied at the next wrap edge. On that edge, active is loaded, pending is cleared and `div_ack` pulses; the strobe of that wrap uses the old ratio.
  - In WAIT_LOCK or HOLD, the pending ratio is applied on the edge after latching, with a `div_ack` pulse.
  - The requester must drop `div_req` on the cycle after it sees `div_ack`. A request still high the cycle after the ack is latched as a new request.
- **Simultaneous events:**
  - A request latched on a wrap edge is applied at the following wrap.
  - Lock loss on the same edge as an apply: the apply completes (ack pulses) and the state goes to WAIT_LOCK.
- **Asynchronous reset mid-operation:** all outputs go to their reset values immediately. The pending request is discarded and no `div_ack` is issued.

## Timing
- Edge numbering: `pll_locked` rises before edge 1.
  - `lock_s` is high after edge 2.
  - `state` = HOLD after edge 3.
  - `dp_rst_n` = 1 after edge 3+LOCK_HOLD.
- First `sample_en` is high after edge 3+LOCK_HOLD+active, then every `active` cycles.
- Lock loss: `pll_locked` falls before edge k, and `dp_rst_n` = 0 after edge k+2.
- `div_ack` latency in RUN: at most active_old+1 cycles after `div_req` is sampled. The first period at the new ratio follows the ack.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- **Lock sequence:** LOCK_HOLD=8, DEF_DIV=4, `pll_locked` rises before edge 1 → HOLD after edge 3, `dp_rst_n` = 1 after edge 11, `sample_en` pulses after edges 15, 19, 23.
- **Glitchy lock:** `pll_locked` high for 5 cycles, then low, then high → returns to WAIT_LOCK and `dp_rst_n` stays 0. The hold count restarts from 0 on the second rise.
- **Divide change in RUN:** active=4, request `div_val`=2 mid-period → one more 4-cycle period ends with `div_ack`, then `sample_en` every 2 cycles. Request `div_val`=0 → `sample_en` constantly high.
- **Lock loss in RUN:** drop `pll_locked` → `dp_rst_n` and `sample_en` are 0 two edges later and `state` = 0. Relock → full LOCK_HOLD delay, and the active ratio is unchanged.
- **Request outside RUN:** `div_req` with `div_val`=7 during HOLD → `div_ack` on the next edge. First RUN strobe arrives 7 cycles after `dp_rst_n` rises.
- **Reset mid-pending:** assert `rst_n` low with a request pending → all outputs 0 asynchronously, no `div_ack`. After release, active = DEF_DIV.

Source files
------------

// File: rtl/clk_seq_ctrl.sv
// clk_seq_ctrl: sequences datapath reset release after PLL lock and
// generates the sample-rate strobe from a run-time adjustable divide ratio.
//
// Divide-change handshake (div_req / div_val / div_ack):
//   The requester raises div_req with div_val and holds both stable until it
//   sees div_ack high. A request is latched on the first edge where div_req is
//   high and no earlier request is pending; while pending, div_req is ignored.
//   div_ack is a one-cycle pulse on the edge the new ratio becomes active.
//   The requester drops div_req during the cycle in which div_ack is high;
//   a div_req still high on the following edge is taken as a fresh request.
module clk_seq_ctrl #(
  parameter int DIV_W     = 16,
  parameter int LOCK_HOLD = 1024,
  parameter int DEF_DIV   = 4
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             dp_rst_n,
  output logic             sample_en,
  output logic [1:0]       state
);

  localparam int HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0]  DIV_DEF   = DIV_W'(DEF_DIV);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  // Lock synchronizer
  logic r_sync1;
  logic r_lock_s;

  // FSM
  state_t r_state;
  state_t w_state_nxt;

  // Counters and divide-ratio registers
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [DIV_W-1:0]  r_active;
  logic [DIV_W-1:0]  r_pend_val;
  logic              r_pending;

  // Registered outputs and their next values
  logic r_div_ack;
  logic r_dp_rst_n;
  logic r_sample_en;
  logic w_div_ack_nxt;
  logic w_dp_rst_n_nxt;
  logic w_sample_en_nxt;

  // Datapath decode
  logic             w_wrap;
  logic             w_apply;
  logic             w_latch;
  logic [DIV_W-1:0] w_req_val;

  // End of a sample period: counter has reached active-1 while running.
  assign w_wrap    = (r_state == ST_RUN) && (r_div_cnt == (r_active - DIV_ONE));
  // Outside RUN there is no period to respect, so a pending ratio applies at once.
  assign w_apply   = r_pending && ((r_state != ST_RUN) || w_wrap);
  assign w_latch   = div_req && !r_pending;
  assign w_req_val = (div_val == '0) ? DIV_ONE : div_val;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_locked;
      r_lock_s <= r_sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_WAIT_LOCK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic: lock loss from any state returns to WAIT_LOCK.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (r_lock_s) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!r_lock_s)                   w_state_nxt = ST_WAIT_LOCK;
        else if (r_hold_cnt == HOLD_LAST) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!r_lock_s) w_state_nxt = ST_WAIT_LOCK;
      end
      default: w_state_nxt = ST_WAIT_LOCK;
    endcase
  end

  // FSM output logic: next values for the registered outputs.
  always_comb begin
    w_dp_rst_n_nxt  = (w_state_nxt == ST_RUN);
    w_sample_en_nxt = (r_state == ST_RUN) && r_lock_s && w_wrap;
    w_div_ack_nxt   = w_apply;
  end

  // Output registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_rst_n  <= 1'b0;
      r_sample_en <= 1'b0;
      r_div_ack   <= 1'b0;
    end else begin
      r_dp_rst_n  <= w_dp_rst_n_nxt;
      r_sample_en <= w_sample_en_nxt;
      r_div_ack   <= w_div_ack_nxt;
    end
  end

  // Hold counter: zero while waiting for lock, counts up through HOLD.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (r_state == ST_HOLD) begin
      r_hold_cnt <= r_hold_cnt + HOLD_ONE;
    end else begin
      r_hold_cnt <= '0;
    end
  end

  // Divide counter: cleared until RUN is entered, then wraps at active-1.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (r_state != ST_RUN) begin
      r_div_cnt <= '0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_ONE;
    end
  end

  // Divide ratio: latch a request into pending, promote it to active on apply.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= DIV_DEF;
      r_pend_val <= '0;
      r_pending  <= 1'b0;
    end else if (w_apply) begin
      r_active  <= r_pend_val;
      r_pending <= 1'b0;
    end else if (w_latch) begin
      r_pend_val <= w_req_val;
      r_pending  <= 1'b1;
    end
  end

  assign div_ack   = r_div_ack;
  assign dp_rst_n  = r_dp_rst_n;
  assign sample_en = r_sample_en;
  assign state     = r_state;

endmodule

// File: tb/tb_clk_seq_ctrl.sv
// tb_clk_seq_ctrl: table-driven checks of lock sequencing, divide changes,
// lock loss and asynchronous reset for clk_seq_ctrl (LOCK_HOLD=8, DEF_DIV=4).
module tb_clk_seq_ctrl;

  localparam int DIV_W = 16;
  localparam int LH    = 8;
  localparam int DEFD  = 4;

  // Clock / reset block
  logic             sys_clk;
  logic             rst_n;
  logic             pll_locked;
  logic             div_req;
  logic [DIV_W-1:0] div_val;
  logic             div_ack;
  logic             dp_rst_n;
  logic             sample_en;
  logic [1:0]       state;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  clk_seq_ctrl #(.DIV_W(DIV_W), .LOCK_HOLD(LH), .DEF_DIV(DEFD)) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .div_req    (div_req),
    .div_val    (div_val),
    .div_ack    (div_ack),
    .dp_rst_n   (dp_rst_n),
    .sample_en  (sample_en),
    .state      (state)
  );

  // Vector table: one record per clock edge, expected = {state, dp_rst_n, sample_en, div_ack}
  typedef struct {
    logic             pll;
    logic             req;
    logic [DIV_W-1:0] val;
    logic [4:0]       exp;
  } vec_t;

  vec_t       tbl [64];
  logic [4:0] exp_q [$];
  int         n_vec  = 0;
  int         n_miss = 0;

  function automatic logic [4:0] mk(logic [1:0] st, logic dp, logic se, logic ack);
    return {st, dp, se, ack};
  endfunction

  task automatic sv(int idx, logic pll, logic req, int val,
                    logic [1:0] st, logic dp, logic se, logic ack);
    tbl[idx].pll = pll;
    tbl[idx].req = req;
    tbl[idx].val = DIV_W'(val);
    tbl[idx].exp = mk(st, dp, se, ack);
  endtask

  // Lock sequence from the timing rules: pll high before edge 1, HOLD after
  // edge 3, dp_rst_n after edge 3+LH, strobes every act edges after that.
  task automatic fill_lock(int base, int n, int act);
    for (int e = 1; e <= n; e++) begin
      if (e < 3)
        sv(base + e - 1, 1'b1, 1'b0, 0, 2'd0, 1'b0, 1'b0, 1'b0);
      else if (e < 3 + LH)
        sv(base + e - 1, 1'b1, 1'b0, 0, 2'd1, 1'b0, 1'b0, 1'b0);
      else
        sv(base + e - 1, 1'b1, 1'b0, 0, 2'd2, 1'b1,
           ((e >= 3 + LH + act) && (((e - 3 - LH) % act) == 0)), 1'b0);
    end
  endtask

  task automatic compare(string tag, int idx, logic [4:0] got, logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got state=%0d dp_rst_n=%0b sample_en=%0b div_ack=%0b, expected state=%0d dp_rst_n=%0b sample_en=%0b div_ack=%0b",
               tag, idx, got[4:3], got[2], got[1], got[0], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Driver + scoreboard: push expectation on drive, pop after the edge.
  task automatic apply_table(string tag, int n);
    logic [4:0] got;
    logic [4:0] exp;
    for (int i = 0; i < n; i++) begin
      pll_locked = tbl[i].pll;
      div_req    = tbl[i].req;
      div_val    = tbl[i].val;
      exp_q.push_back(tbl[i].exp);
      @(posedge sys_clk);
      #1;
      got = {state, dp_rst_n, sample_en, div_ack};
      exp = exp_q.pop_front();
      compare(tag, i + 1, got, exp);
    end
  endtask

  task automatic check_now(string tag, logic [4:0] exp);
    compare(tag, 0, {state, dp_rst_n, sample_en, div_ack}, exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    div_req    = 1'b0;
    div_val    = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check_now("reset", mk(2'd0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;

    // Lock sequence, divide change 4->2->0(=1) in RUN, lock loss, relock.
    fill_lock(0, 24, 4);
    sv(24, 1'b1, 1'b1, 2, 2'd2, 1'b1, 1'b0, 1'b0);
    sv(25, 1'b1, 1'b1, 2, 2'd2, 1'b1, 1'b0, 1'b0);
    sv(26, 1'b1, 1'b1, 2, 2'd2, 1'b1, 1'b1, 1'b1);
    sv(27, 1'b1, 1'b0, 0, 2'd2, 1'b1, 1'b0, 1'b0);
    sv(28, 1'b1, 1'b0, 0, 2'd2, 1'b1, 1'b1, 1'b0);
    sv(29, 1'b1, 1'b0, 0, 2'd2, 1'b1, 1'b0, 1'b0);
    sv(30, 1'b1, 1'b0, 0, 2'd2, 1'b1, 1'b1, 1'b0);
    sv(31, 1'b1, 1'b1, 0, 2'd2, 1'b1, 1'b0, 1'b0);
    sv(32, 1'b1, 1'b1, 0, 2'd2, 1'b1, 1'b1, 1'b1);
    for (int i = 33; i <= 36; i++) sv(i, 1'b1, 1'b0, 0, 2'd2, 1'b1, 1'b1, 1'b0);
    sv(37, 1'b0, 1'b0, 0, 2'd2, 1'b1, 1'b1, 1'b0);
    sv(38, 1'b0, 1'b0, 0, 2'd2, 1'b1, 1'b1, 1'b0);
    sv(39, 1'b0, 1'b0, 0, 2'd0, 1'b0, 1'b0, 1'b0);
    sv(40, 1'b0, 1'b0, 0, 2'd0, 1'b0, 1'b0, 1'b0);
    fill_lock(41, 13, 1);
    apply_table("lock_div_loss", 54);

    // Asynchronous reset while running: outputs clear without a clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    check_now("async_reset_run", mk(2'd0, 1'b0, 1'b0, 1'b0));
    pll_locked = 1'b0;
    @(posedge sys_clk);
    #1;
    rst_n = 1'b1;

    // Glitchy lock, then request of 7 during HOLD, then first strobe 7 later.
    for (int i = 0; i <= 4; i++)
      sv(i, 1'b1, 1'b0, 0, (i < 2) ? 2'd0 : 2'd1, 1'b0, 1'b0, 1'b0);
    sv(5, 1'b0, 1'b0, 0, 2'd1, 1'b0, 1'b0, 1'b0);
    sv(6, 1'b0, 1'b0, 0, 2'd1, 1'b0, 1'b0, 1'b0);
    sv(7, 1'b0, 1'b0, 0, 2'd0, 1'b0, 1'b0, 1'b0);
    sv(8, 1'b1, 1'b0, 0, 2'd0, 1'b0, 1'b0, 1'b0);
    sv(9, 1'b1, 1'b0, 0, 2'd0, 1'b0, 1'b0, 1'b0);
    sv(10, 1'b1, 1'b0, 0, 2'd1, 1'b0, 1'b0, 1'b0);
    sv(11, 1'b1, 1'b0, 0, 2'd1, 1'b0, 1'b0, 1'b0);
    sv(12, 1'b1, 1'b1, 7, 2'd1, 1'b0, 1'b0, 1'b0);
    sv(13, 1'b1, 1'b1, 7, 2'd1, 1'b0, 1'b0, 1'b1);
    for (int i = 14; i <= 17; i++) sv(i, 1'b1, 1'b0, 0, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 18; i <= 24; i++) sv(i, 1'b1, 1'b0, 0, 2'd2, 1'b1, 1'b0, 1'b0);
    sv(25, 1'b1, 1'b0, 0, 2'd2, 1'b1, 1'b1, 1'b0);
    sv(26, 1'b1, 1'b0, 0, 2'd2, 1'b1, 1'b0, 1'b0);
    sv(27, 1'b1, 1'b1, 3, 2'd2, 1'b1, 1'b0, 1'b0);
    apply_table("glitch_hold_req", 28);

    // Reset with a request pending: no ack, and the default ratio returns.
    #3;
    rst_n = 1'b0;
    #1;
    check_now("async_reset_pending", mk(2'd0, 1'b0, 1'b0, 1'b0));
    div_req = 1'b0;
    div_val = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge sys_clk);
      #1;
      check_now("reset_held", mk(2'd0, 1'b0, 1'b0, 1'b0));
    end
    rst_n = 1'b1;
    fill_lock(0, 16, DEFD);
    apply_table("after_reset_default", 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
